// File: rtl/bignum_pkg.sv
// Shared types and helpers for the streaming bignum add/subtract engine.
package bignum_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Ceiling log2; a counter that must reach n needs clog2(n+1) bits.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Result word buffer between the carry chain and the write port.
// head reads as zero while empty so an idle write port shows no stale data.
module word_fifo
    import bignum_pkg::*;
#(
    parameter int WIDTH = WORD_W_DEF,
    parameter int DEPTH = 4,
    parameter int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bignum_addsub_stream.sv
// Streaming multi-word add/subtract: paired LS-first reads, rippled carry, buffered writes.
// Subtract mode is compiled in only when BIGNUM_SUB_EN is defined.
//
//  state | meaning
//  IDLE  | waiting for start_in; carry_out holds last result
//  RUN   | issuing reads while credits remain; results stream out
//  DRAIN | all reads issued; finishing returns and writes
//  DONE  | one-cycle done_out pulse
module bignum_addsub_stream
    import bignum_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int NUM_BITS   = 2048,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic              sub_in,
    input  logic [ADDR_W-1:0] x_pointer_in,
    input  logic [ADDR_W-1:0] y_pointer_in,
    input  logic [ADDR_W-1:0] result_pointer_in,
    output logic              request_valid_out,
    input  logic              request_ready_in,
    output logic [ADDR_W-1:0] x_request_out,
    output logic [ADDR_W-1:0] y_request_out,
    input  logic              received_valid_in,
    input  logic [WORD_W-1:0] x_data_in,
    input  logic [WORD_W-1:0] y_data_in,
    output logic              valid_write_out,
    input  logic              write_ready_in,
    output logic [WORD_W-1:0] data_to_store_out,
    output logic [ADDR_W-1:0] write_data_pointer_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              carry_out
);

    localparam int NUM_WORDS = NUM_BITS / WORD_W;
    localparam int IDX_W     = clog2(NUM_WORDS + 1);
    localparam int OCC_W     = clog2(FIFO_DEPTH + 1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] x_base;
    logic [ADDR_W-1:0] y_base;
    logic [ADDR_W-1:0] r_base;
    logic [IDX_W-1:0]  read_idx;
    logic [IDX_W-1:0]  write_idx;
    logic [IDX_W-1:0]  comp_idx;
    logic [OCC_W-1:0]  in_flight;
    logic [OCC_W-1:0]  occ;
    logic              carry;
    logic              sub_sel;
    logic [WORD_W-1:0] y_eff;
    logic [WORD_W:0]   sum;
    logic              fifo_empty;
    logic              req_fire;
    logic              wr_fire;
    logic              rx_accept;
    logic              has_credit;
    logic              last_read;
    logic              last_write;
    logic              start_ok;

`ifdef BIGNUM_SUB_EN
    logic sub_mode;

    assign sub_sel = sub_in;
    assign y_eff   = sub_mode ? ~y_data_in : y_data_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sub_mode <= 1'b0;
        end else if (start_ok) begin
            sub_mode <= sub_in;
        end
    end
`else
    logic unused_sub;

    assign unused_sub = sub_in;
    assign sub_sel    = 1'b0;
    assign y_eff      = y_data_in;
`endif

    assign start_ok   = (state == IDLE) && start_in;
    assign req_fire   = request_valid_out && request_ready_in;
    assign wr_fire    = valid_write_out && write_ready_in;
    // Returns with nothing outstanding (protocol error or pre-reset leftovers) are dropped.
    assign rx_accept  = received_valid_in && (in_flight != '0);
    assign has_credit = ({1'b0, in_flight} + {1'b0, occ}) < (OCC_W + 1)'(FIFO_DEPTH);
    assign last_read  = (read_idx == IDX_W'(NUM_WORDS - 1));
    assign last_write = (write_idx == IDX_W'(NUM_WORDS - 1));
    assign sum        = {1'b0, x_data_in} + {1'b0, y_eff} + (WORD_W + 1)'(carry);

    assign x_request_out          = x_base + ADDR_W'(read_idx);
    assign y_request_out          = y_base + ADDR_W'(read_idx);
    assign write_data_pointer_out = r_base + ADDR_W'(write_idx);
    assign valid_write_out        = !fifo_empty;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_in) next_state = RUN;
            RUN:     if (req_fire && last_read) next_state = DRAIN;
            DRAIN:   if (wr_fire && last_write) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        request_valid_out = 1'b0;
        busy_out          = 1'b0;
        done_out          = 1'b0;
        case (state)
            RUN: begin
                busy_out          = 1'b1;
                request_valid_out = has_credit;
            end
            DRAIN:   busy_out = 1'b1;
            DONE:    done_out = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x_base    <= '0;
            y_base    <= '0;
            r_base    <= '0;
            read_idx  <= '0;
            write_idx <= '0;
            comp_idx  <= '0;
            carry     <= 1'b0;
            carry_out <= 1'b0;
        end else if (start_ok) begin
            x_base    <= x_pointer_in;
            y_base    <= y_pointer_in;
            r_base    <= result_pointer_in;
            read_idx  <= '0;
            write_idx <= '0;
            comp_idx  <= '0;
            carry     <= sub_sel;
            carry_out <= 1'b0;
        end else begin
            if (req_fire) begin
                read_idx <= read_idx + IDX_W'(1);
            end
            if (wr_fire) begin
                write_idx <= write_idx + IDX_W'(1);
            end
            if (rx_accept) begin
                carry    <= sum[WORD_W];
                comp_idx <= comp_idx + IDX_W'(1);
                if (comp_idx == IDX_W'(NUM_WORDS - 1)) begin
                    carry_out <= sum[WORD_W];
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            in_flight <= '0;
        end else begin
            case ({req_fire, rx_accept})
                2'b10:   in_flight <= in_flight + OCC_W'(1);
                2'b01:   in_flight <= in_flight - OCC_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (OCC_W)
    ) u_fifo (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .push      (rx_accept),
        .push_data (sum[WORD_W-1:0]),
        .pop       (wr_fire),
        .head      (data_to_store_out),
        .empty     (fifo_empty),
        .count     (occ)
    );

endmodule

// File: tb/tb_bignum_addsub_stream.sv
// Directed bench for bignum_addsub_stream: memory responder with fixed read latency,
// whole-operand arithmetic model, and a per-cycle write checker.
module tb_bignum_addsub_stream;

    localparam int WORD_W     = 32;
    localparam int NUM_BITS   = 2048;
    localparam int ADDR_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int NUM_WORDS  = NUM_BITS / WORD_W;
    localparam int LAT        = 2;
`ifdef BIGNUM_SUB_EN
    localparam bit SUB_OK = 1'b1;
`else
    localparam bit SUB_OK = 1'b0;
`endif

    logic              clk_in;
    logic              rst_n_in;
    logic              start_in;
    logic              sub_in;
    logic [ADDR_W-1:0] x_pointer_in;
    logic [ADDR_W-1:0] y_pointer_in;
    logic [ADDR_W-1:0] result_pointer_in;
    logic              request_valid_out;
    logic              request_ready_in;
    logic [ADDR_W-1:0] x_request_out;
    logic [ADDR_W-1:0] y_request_out;
    logic              received_valid_in;
    logic [WORD_W-1:0] x_data_in;
    logic [WORD_W-1:0] y_data_in;
    logic              valid_write_out;
    logic              write_ready_in;
    logic [WORD_W-1:0] data_to_store_out;
    logic [ADDR_W-1:0] write_data_pointer_out;
    logic              busy_out;
    logic              done_out;
    logic              carry_out;

    bignum_addsub_stream #(
        .WORD_W     (WORD_W),
        .NUM_BITS   (NUM_BITS),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_in                 (clk_in),
        .rst_n_in               (rst_n_in),
        .start_in               (start_in),
        .sub_in                 (sub_in),
        .x_pointer_in           (x_pointer_in),
        .y_pointer_in           (y_pointer_in),
        .result_pointer_in      (result_pointer_in),
        .request_valid_out      (request_valid_out),
        .request_ready_in       (request_ready_in),
        .x_request_out          (x_request_out),
        .y_request_out          (y_request_out),
        .received_valid_in      (received_valid_in),
        .x_data_in              (x_data_in),
        .y_data_in              (y_data_in),
        .valid_write_out        (valid_write_out),
        .write_ready_in         (write_ready_in),
        .data_to_store_out      (data_to_store_out),
        .write_data_pointer_out (write_data_pointer_out),
        .busy_out               (busy_out),
        .done_out               (done_out),
        .carry_out              (carry_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        int               due;
        logic [ADDR_W-1:0] xa;
        logic [ADDR_W-1:0] ya;
    } rd_t;

    logic [WORD_W-1:0] mem [256];
    logic [WORD_W-1:0] exp_word [NUM_WORDS];
    logic [ADDR_W-1:0] exp_rbase;
    logic [ADDR_W-1:0] x_addrs [$];
    rd_t               pend [$];
    bit                exp_carry;
    bit                exp_active;
    bit                rq_rand;
    bit                wr_slow;
    int                exp_idx;
    int                acc_cnt;
    int                wr_cnt;
    int                cyc;
    int                checks;
    int                errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Memory side: returns read data LAT cycles after each accepted request.
    initial begin
        rd_t e;
        cyc = 0;
        forever begin
            @(posedge clk_in);
            #1;
            cyc++;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                received_valid_in = 1'b1;
                x_data_in         = mem[pend[0].xa];
                y_data_in         = mem[pend[0].ya];
                void'(pend.pop_front());
            end else begin
                received_valid_in = 1'b0;
                x_data_in         = $urandom;
                y_data_in         = $urandom;
            end
            request_ready_in = rq_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            write_ready_in   = wr_slow ? (cyc % 3 == 0) : 1'b1;
            if (request_valid_out && request_ready_in) begin
                e.due = cyc + LAT;
                e.xa  = x_request_out;
                e.ya  = y_request_out;
                pend.push_back(e);
                x_addrs.push_back(x_request_out);
                acc_cnt++;
            end
        end
    end

    // Compare process: every accepted write against the model, plus the outstanding bound.
    initial begin
        logic [ADDR_W-1:0] ea;
        forever begin
            @(negedge clk_in);
            if (rst_n_in && valid_write_out && write_ready_in) begin
                if (exp_active && exp_idx < NUM_WORDS) begin
                    ea = exp_rbase + ADDR_W'(exp_idx);
                    chk("write_data", 64'(data_to_store_out), 64'(exp_word[exp_idx]));
                    chk("write_addr", 64'(write_data_pointer_out), 64'(ea));
                    exp_idx++;
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h@%0h required=none",
                             data_to_store_out, write_data_pointer_out);
                end
                wr_cnt++;
            end
            if (exp_active) begin
                checks++;
                if (acc_cnt - wr_cnt > FIFO_DEPTH) begin
                    errors++;
                    $display("FAIL outstanding actual=%0d required<=%0d", acc_cnt - wr_cnt, FIFO_DEPTH);
                end
            end
        end
    end

    // Whole-operand model: treat X and Y as NUM_BITS-wide integers.
    task automatic build_expect(input logic [ADDR_W-1:0] xp, input logic [ADDR_W-1:0] yp,
                                input logic [ADDR_W-1:0] rp, input bit sub);
        logic [NUM_BITS:0] xb;
        logic [NUM_BITS:0] yb;
        logic [NUM_BITS:0] rb;
        xb = '0;
        yb = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            xb[k*WORD_W +: WORD_W] = mem[(int'(xp) + k) % 256];
            yb[k*WORD_W +: WORD_W] = mem[(int'(yp) + k) % 256];
        end
        if (sub && SUB_OK) begin
            rb        = xb - yb;
            exp_carry = !rb[NUM_BITS];
        end else begin
            rb        = xb + yb;
            exp_carry = rb[NUM_BITS];
        end
        for (int k = 0; k < NUM_WORDS; k++) begin
            exp_word[k] = rb[k*WORD_W +: WORD_W];
        end
        exp_rbase = rp;
    endtask

    task automatic load(input logic [ADDR_W-1:0] base, input logic [WORD_W-1:0] w0,
                        input logic [WORD_W-1:0] rest);
        for (int k = 0; k < NUM_WORDS; k++) begin
            mem[(int'(base) + k) % 256] = (k == 0) ? w0 : rest;
        end
    endtask

    task automatic load_random(input logic [ADDR_W-1:0] base);
        for (int k = 0; k < NUM_WORDS; k++) begin
            mem[(int'(base) + k) % 256] = $urandom;
        end
    endtask

    task automatic run_op(input string name, input logic [ADDR_W-1:0] xp,
                          input logic [ADDR_W-1:0] yp, input logic [ADDR_W-1:0] rp,
                          input bit sub, input int exp_cycles, input bit mid_start);
        int cnt;
        bit seen;
        build_expect(xp, yp, rp, sub);
        exp_idx    = 0;
        exp_active = 1'b1;
        x_addrs.delete();
        @(negedge clk_in);
        start_in          = 1'b1;
        sub_in            = sub;
        x_pointer_in      = xp;
        y_pointer_in      = yp;
        result_pointer_in = rp;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 2000) begin
            @(negedge clk_in);
            cnt++;
            if (cnt == 1) start_in = 1'b0;
            if (cnt == 5) chk({name, "_busy"}, 64'(busy_out), 64'(1));
            if (mid_start && cnt == 10) begin
                start_in          = 1'b1;
                sub_in            = !sub;
                x_pointer_in      = ~xp;
                y_pointer_in      = xp;
                result_pointer_in = rp + 8'd100;
            end
            if (mid_start && cnt == 11) start_in = 1'b0;
            if (done_out) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout actual=none required=done_out", name);
        end else begin
            if (exp_cycles > 0) chk({name, "_latency"}, 64'(cnt), 64'(exp_cycles));
            chk({name, "_words"}, 64'(exp_idx), 64'(NUM_WORDS));
            chk({name, "_carry"}, 64'(carry_out), 64'(exp_carry));
            chk({name, "_busy_done"}, 64'(busy_out), 64'(0));
        end
        @(negedge clk_in);
        @(negedge clk_in);
        chk({name, "_carry_held"}, 64'(carry_out), 64'(exp_carry));
        chk({name, "_done_pulse"}, 64'(done_out), 64'(0));
        exp_active = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int cnt;
        checks = 0;
        errors = 0;
        acc_cnt = 0;
        wr_cnt = 0;
        exp_idx = 0;
        exp_active = 1'b0;
        rq_rand = 1'b0;
        wr_slow = 1'b0;
        rst_n_in = 1'b0;
        start_in = 1'b0;
        sub_in = 1'b0;
        x_pointer_in = '0;
        y_pointer_in = '0;
        result_pointer_in = '0;
        request_ready_in = 1'b0;
        received_valid_in = 1'b0;
        write_ready_in = 1'b0;
        x_data_in = '0;
        y_data_in = '0;
        for (int a = 0; a < 256; a++) mem[a] = '0;

        repeat (3) @(negedge clk_in);
        chk("reset_outputs", 64'({request_valid_out, x_request_out, y_request_out, valid_write_out,
                                  data_to_store_out, write_data_pointer_out, busy_out, done_out,
                                  carry_out}), 64'(0));
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // 1: all-ones + 1 -> zeros, carry out, minimum latency NUM_WORDS + LAT + 2
        load(8'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        load(8'd64, 32'd1, 32'd0);
        build_expect(8'd0, 8'd64, 8'd128, 1'b0);
        chk("model_c1_word0", 64'(exp_word[0]), 64'(0));
        chk("model_c1_word63", 64'(exp_word[63]), 64'(0));
        chk("model_c1_carry", 64'(exp_carry), 64'(1));
        run_op("c1_add", 8'd0, 8'd64, 8'd128, 1'b0, NUM_WORDS + LAT + 2, 1'b0);

        // 2: subtract (adds when the feature is compiled out)
        load(8'd0, 32'd5, 32'd0);
        load(8'd64, 32'd3, 32'd0);
        build_expect(8'd0, 8'd64, 8'd128, 1'b1);
        chk("model_c2a_word0", 64'(exp_word[0]), SUB_OK ? 64'd2 : 64'd8);
        chk("model_c2a_carry", 64'(exp_carry), SUB_OK ? 64'd1 : 64'd0);
        run_op("c2a_sub", 8'd0, 8'd64, 8'd128, 1'b1, NUM_WORDS + LAT + 2, 1'b0);
        load(8'd0, 32'd3, 32'd0);
        load(8'd64, 32'd5, 32'd0);
        build_expect(8'd0, 8'd64, 8'd128, 1'b1);
        chk("model_c2b_word5", 64'(exp_word[5]), SUB_OK ? 64'hFFFF_FFFF : 64'd0);
        chk("model_c2b_carry", 64'(exp_carry), 64'd0);
        run_op("c2b_sub", 8'd0, 8'd64, 8'd128, 1'b1, NUM_WORDS + LAT + 2, 1'b0);

        // 3: backpressure on both ports, same data as case 1
        load(8'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        load(8'd64, 32'd1, 32'd0);
        rq_rand = 1'b1;
        wr_slow = 1'b1;
        run_op("c3_stall", 8'd0, 8'd64, 8'd128, 1'b0, 0, 1'b0);
        rq_rand = 1'b0;
        wr_slow = 1'b0;

        // 4: X pointer wraps the address space
        load_random(8'd250);
        load_random(8'd64);
        run_op("c4_wrap", 8'd250, 8'd64, 8'd200, 1'b0, NUM_WORDS + LAT + 2, 1'b0);
        chk("c4_addr_first", 64'(x_addrs[0]), 64'd250);
        chk("c4_addr_5", 64'(x_addrs[5]), 64'd255);
        chk("c4_addr_6", 64'(x_addrs[6]), 64'd0);
        chk("c4_addr_last", 64'(x_addrs[NUM_WORDS-1]), 64'd57);

        // 5: reset at word 20, late returns dropped, then a fresh operation
        load_random(8'd0);
        load_random(8'd64);
        build_expect(8'd0, 8'd64, 8'd128, 1'b0);
        exp_idx = 0;
        exp_active = 1'b1;
        @(negedge clk_in);
        start_in = 1'b1;
        sub_in = 1'b0;
        x_pointer_in = 8'd0;
        y_pointer_in = 8'd64;
        result_pointer_in = 8'd128;
        @(negedge clk_in);
        start_in = 1'b0;
        cnt = 0;
        while (wr_cnt < 20 && cnt < 500) begin
            @(posedge clk_in);
            cnt++;
        end
        if (cnt >= 500) begin
            checks++;
            errors++;
            $display("FAIL c5_reach_word20 actual=%0d required=20", wr_cnt);
        end
        #3;
        rst_n_in = 1'b0;
        exp_active = 1'b0;
        acc_cnt = 0;
        wr_cnt = 0;
        @(negedge clk_in);
        chk("c5_reset_outputs", 64'({request_valid_out, x_request_out, y_request_out, valid_write_out,
                                     data_to_store_out, write_data_pointer_out, busy_out, done_out,
                                     carry_out}), 64'(0));
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (6) @(negedge clk_in);
        chk("c5_idle_busy", 64'(busy_out), 64'(0));
        chk("c5_idle_write", 64'(valid_write_out), 64'(0));
        chk("c5_idle_request", 64'(request_valid_out), 64'(0));
        acc_cnt = 0;
        wr_cnt = 0;
        run_op("c5_fresh", 8'd0, 8'd64, 8'd128, 1'b0, NUM_WORDS + LAT + 2, 1'b0);

        // 6: start pulse during RUN with other settings is ignored
        load_random(8'd0);
        load_random(8'd64);
        run_op("c6_midstart", 8'd0, 8'd64, 8'd128, 1'b0, NUM_WORDS + LAT + 2, 1'b1);

        repeat (4) @(negedge clk_in);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
